// File: rtl/result_stream_packer.sv
// Drains the two Cell Score Filter result buffers and packs up to three 41-bit results
// into one 128-bit stream word; a partial word is flushed after an idle timeout.
//  state | meaning
//  FILL  | pack holds 0..2 results, accepts whenever enabled
//  FULL  | pack holds 3 results, accepts only on the edge it moves to the output
module result_stream_packer #(
   parameter int RESULT_W      = 41,
   parameter int FLUSH_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [RESULT_W-1:0] result_0_data_in,
   input  logic                result_0_valid_in,
   output logic                result_0_rdy_out,
   input  logic [RESULT_W-1:0] result_1_data_in,
   input  logic                result_1_valid_in,
   output logic                result_1_rdy_out,
   output logic [127:0]        so_data,
   output logic                so_valid,
   input  logic                so_rdy
);
   localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic                     enable;
   logic                     last_grant;
   logic                     grant;
   logic                     grant_valid;
   logic [RESULT_W-1:0]      grant_data;
   logic                     out_free;
   logic                     flush_due;
   logic                     move;
   logic                     accept_ok;
   logic                     accept;
   logic [1:0]               count;
   logic [1:0]               count_nxt;
   logic [1:0]               wr_idx;
   logic [2:0][RESULT_W-1:0] slot;
   logic [2:0]               src;
   logic [IDLE_W-1:0]        idle_cnt;

   // Round-robin only matters when both buffers offer; otherwise the valid one wins.
   always_comb begin
      grant       = (result_0_valid_in && result_1_valid_in) ? !last_grant : result_1_valid_in;
      grant_valid = grant ? result_1_valid_in : result_0_valid_in;
      grant_data  = grant ? result_1_data_in : result_0_data_in;
      out_free    = !so_valid || so_rdy;
      flush_due   = (count != 2'd0) && (idle_cnt >= IDLE_W'(FLUSH_TIMEOUT));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FILL;
      else      state <= state_nxt;
   end

   always_comb begin
      wr_idx    = move ? 2'd0 : count;
      count_nxt = move ? {1'b0, accept} : count + {1'b0, accept};
      state_nxt = (count_nxt == 2'd3) ? FULL : FILL;
   end

   always_comb begin
      move             = out_free && ((state == FULL) || flush_due);
      accept_ok        = enable && ((state == FILL) || move);
      accept           = accept_ok && grant_valid;
      result_0_rdy_out = accept_ok && !grant;
      result_1_rdy_out = accept_ok && grant;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enable     <= 1'b0;
         last_grant <= 1'b1;
         count      <= 2'd0;
         slot       <= '0;
         src        <= '0;
         idle_cnt   <= '0;
         so_data    <= '0;
         so_valid   <= 1'b0;
      end else begin
         enable <= 1'b1;
         count  <= count_nxt;
         if (accept) last_grant <= grant;

         if (move) begin
            so_data  <= {src, count, slot[2], slot[1], slot[0]};
            so_valid <= 1'b1;
         end else if (so_rdy) begin
            so_valid <= 1'b0;
         end

         // Clearing on move keeps unused slots and source bits zero in the next word.
         if (move) begin
            slot <= '0;
            src  <= '0;
         end
         if (accept) begin
            slot[wr_idx] <= grant_data;
            src[wr_idx]  <= grant;
         end

         if (accept || move)
            idle_cnt <= '0;
         else if ((count != 2'd0) && (idle_cnt != IDLE_W'(FLUSH_TIMEOUT)))
            idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
endmodule

// File: tb/tb_result_stream_packer.sv
// Directed bench for result_stream_packer: expected words are queued as stimulus is
// planned and checked against each output handshake.
module tb_result_stream_packer;
   localparam int RW = 41;
   localparam int FT = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] r0_d, r1_d;
   logic          r0_v, r1_v;
   logic          rdy0, rdy1;
   logic [127:0]  so_data;
   logic          so_valid;
   logic          so_rdy;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [127:0] exp_q[$];

   result_stream_packer #(.RESULT_W(RW), .FLUSH_TIMEOUT(FT)) dut (
      .clk(clk), .rst(rst),
      .result_0_data_in(r0_d), .result_0_valid_in(r0_v), .result_0_rdy_out(rdy0),
      .result_1_data_in(r1_d), .result_1_valid_in(r1_v), .result_1_rdy_out(rdy1),
      .so_data(so_data), .so_valid(so_valid), .so_rdy(so_rdy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] mk(input logic [1:0] n, input logic [2:0] s,
                                       input logic [RW-1:0] a, input logic [RW-1:0] b,
                                       input logic [RW-1:0] c);
      logic [127:0] w;
      w = '0;
      w[40:0]    = a;
      w[81:41]   = b;
      w[122:82]  = c;
      w[124:123] = n;
      w[127:125] = s;
      return w;
   endfunction

   function automatic logic [RW-1:0] res(input int k);
      return {9'(k), 32'hC0DE_0000 | 32'(k * 97)};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every handshake pops one expected word; held words must not change.
   logic         prev_hold = 1'b0;
   logic         prev_rst  = 1'b0;
   logic [127:0] prev_data = '0;
   logic [127:0] exp_w;
   always @(negedge clk) begin
      if (rst && prev_rst && prev_hold) begin
         n_assert++;
         assert (so_valid === 1'b1 && so_data === prev_data) else begin
            n_fail++;
            $error("FAIL hold: observed valid=%b data=%h expected valid=1 data=%h",
                   so_valid, so_data, prev_data);
         end
      end
      prev_hold = so_valid && !so_rdy;
      prev_data = so_data;
      prev_rst  = rst;
      if (rst && so_valid && so_rdy) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL word_unexpected: observed %h expected no word", so_data);
         end
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            n_assert++;
            assert (so_data === exp_w) else begin
               n_fail++;
               $error("FAIL word: observed %h expected %h", so_data, exp_w);
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input bit b, input logic [RW-1:0] d, output int acc);
      int  tries;
      bit  done;
      tries = 0;
      done  = 1'b0;
      if (b) begin r1_d = d; r1_v = 1'b1; end
      else   begin r0_d = d; r0_v = 1'b1; end
      while (!done && tries < 200) begin
         @(negedge clk);
         if ((b ? rdy1 : rdy0) === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
         tries++;
      end
      if (b) r1_v = 1'b0;
      else   r0_v = 1'b0;
      acc = cyc;
      check("send_accepted", 128'(done), 128'(1));
   endtask

   task automatic wait_valid(output int at);
      int tries;
      tries = 0;
      at    = -1;
      while (at < 0 && tries < 100) begin
         @(negedge clk);
         if (so_valid === 1'b1) at = cyc;
         tries++;
      end
   endtask

   task automatic wait_drain();
      int tries;
      tries = 0;
      while ((exp_q.size() != 0 || so_valid !== 1'b0) && tries < 200) begin
         @(negedge clk);
         tries++;
      end
      @(posedge clk);
      #1;
      check("drain_pending", 128'(exp_q.size()), 128'(0));
   endtask

   logic [RW-1:0] xs[6];
   logic [RW-1:0] ys[6];
   logic [RW-1:0] ds[7];
   int acc, acc2, at, ix, iy, both_rdy, loops, stall_rdy;
   bit a0, a1;

   initial begin
      rst = 1'b0; r0_v = 1'b1; r0_d = res(900); r1_v = 1'b0; r1_d = '0; so_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin xs[i] = res(10 + i); ys[i] = res(20 + i); end
      for (int i = 0; i < 7; i++) ds[i] = res(40 + i);

      // reset values, and no transfer in the cycle right after release
      repeat (2) @(posedge clk);
      #1;
      check("rst_so_valid", 128'(so_valid), 128'(0));
      check("rst_so_data", so_data, 128'(0));
      check("rst_rdy0", 128'(rdy0), 128'(0));
      rst = 1'b1;
      @(negedge clk);
      check("enable_delay_rdy0", 128'(rdy0), 128'(0));
      @(posedge clk);
      #1;
      r0_v = 1'b0;

      // 1: three back-to-back results from buffer 0
      exp_q.push_back(mk(2'd3, 3'b000, res(1), res(2), res(3)));
      send(1'b0, res(1), acc);
      send(1'b0, res(2), acc);
      send(1'b0, res(3), acc);
      wait_valid(at);
      check("full_latency", 128'(at - acc + 1), 128'(2));
      wait_drain();

      // 2: both buffers continuously valid; buffer 0 won last, so buffer 1 goes first
      exp_q.push_back(mk(2'd3, 3'b101, ys[0], xs[0], ys[1]));
      exp_q.push_back(mk(2'd3, 3'b010, xs[1], ys[2], xs[2]));
      exp_q.push_back(mk(2'd3, 3'b101, ys[3], xs[3], ys[4]));
      exp_q.push_back(mk(2'd3, 3'b010, xs[4], ys[5], xs[5]));
      ix = 0; iy = 0; both_rdy = 0; loops = 0;
      while ((ix < 6 || iy < 6) && loops < 100) begin
         r0_v = (ix < 6);
         if (ix < 6) r0_d = xs[ix];
         r1_v = (iy < 6);
         if (iy < 6) r1_d = ys[iy];
         @(negedge clk);
         a0 = r0_v && rdy0;
         a1 = r1_v && rdy1;
         if (rdy0 && rdy1) both_rdy++;
         @(posedge clk);
         #1;
         if (a0) ix++;
         if (a1) iy++;
         loops++;
      end
      r0_v = 1'b0; r1_v = 1'b0;
      check("arb_x_count", 128'(ix), 128'(6));
      check("arb_y_count", 128'(iy), 128'(6));
      check("arb_both_rdy", 128'(both_rdy), 128'(0));
      wait_drain();

      // 3: backpressure - six results fit (output word + full pack), the seventh waits
      exp_q.push_back(mk(2'd3, 3'b000, ds[0], ds[1], ds[2]));
      exp_q.push_back(mk(2'd3, 3'b000, ds[3], ds[4], ds[5]));
      exp_q.push_back(mk(2'd1, 3'b000, ds[6], '0, '0));
      so_rdy = 1'b0;
      for (int i = 0; i < 6; i++) send(1'b0, ds[i], acc);
      r0_d = ds[6]; r0_v = 1'b1; stall_rdy = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rdy0 !== 1'b0 || rdy1 !== 1'b0) stall_rdy++;
         @(posedge clk);
         #1;
      end
      check("stall_rdy_low", 128'(stall_rdy), 128'(0));
      check("stall_so_valid", 128'(so_valid), 128'(1));
      so_rdy = 1'b1;
      send(1'b0, ds[6], acc);
      wait_drain();

      // 4: single result from buffer 1 is flushed after the idle timeout
      exp_q.push_back(mk(2'd1, 3'b001, res(77), '0, '0));
      send(1'b1, res(77), acc);
      wait_valid(at);
      check("flush_latency", 128'(at - acc + 1), 128'(FT + 2));
      wait_drain();

      // 6: new result accepted on the same edge as the flush lands in slot 0
      exp_q.push_back(mk(2'd1, 3'b000, res(80), '0, '0));
      exp_q.push_back(mk(2'd1, 3'b000, res(81), '0, '0));
      send(1'b0, res(80), acc);
      repeat (FT) @(posedge clk);
      #1;
      send(1'b0, res(81), acc2);
      check("flush_accept_edge", 128'(acc2 - acc), 128'(FT + 1));
      wait_drain();

      // 5: reset with a word pending and two results packed discards both
      so_rdy = 1'b0;
      for (int i = 0; i < 5; i++) send(1'b0, res(60 + i), acc);
      check("pre_rst_so_valid", 128'(so_valid), 128'(1));
      r0_d = res(99); r0_v = 1'b1;
      rst = 1'b0;
      #1;
      check("mid_rst_so_valid", 128'(so_valid), 128'(0));
      check("mid_rst_so_data", so_data, 128'(0));
      check("mid_rst_rdy0", 128'(rdy0), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_rdy0", 128'(rdy0), 128'(0));
      @(posedge clk);
      #1;
      r0_v = 1'b0;
      so_rdy = 1'b1;
      exp_q.push_back(mk(2'd1, 3'b000, res(90), '0, '0));
      send(1'b0, res(90), acc);
      wait_drain();

      check("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
